// File: rtl/cl_fsb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cl_fsb_pkg
//  Description : Shared AXI-Lite definitions for the cl_fsb control/status
//                endpoints. Holds response codes, the per-port address window
//                width and the write/read responder state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cl_fsb_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    // Each crossbar port owns a 4 KB window; word index is addr[11:2].
    localparam int AXIL_WIN_ADDR_BITS = 12;
    localparam int AXIL_IDX_W         = AXIL_WIN_ADDR_BITS - 2;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } axil_wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } axil_rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axil_bus_t.sv
`default_nettype none
// ============================================================================
//  Module      : axil_bus_t
//  Description : AXI-Lite bus bundle, 32-bit address/data. The "master"
//                modport is the responder view used by register endpoints;
//                "initiator" is the requesting side.
//  Ports       : AW/W/B/AR/R channel signals (no prot/user fields)
//  Revision    : 1.0 - initial release
// ============================================================================
interface axil_bus_t;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport initiator (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_regfile_responder_join.sv
`default_nettype none
// ============================================================================
//  Module      : axil_aw_w_join
//  Description : Captures one AW beat and one W beat, in either order or in
//                the same cycle, and presents them as a single write request
//                for exactly one cycle (the cycle that enters W_RESP). Holds
//                the response phase until the B handshake.
//  Ports       : aclk, aresetn         clock, synchronous active-low reset
//                awaddr_i/awvalid_i/awready_o   AW channel
//                wdata_i/wstrb_i/wvalid_i/wready_o  W channel
//                req_v_o/req_addr_o/req_data_o/req_strb_o  commit request
//                resp_pend_o           B response pending (drives bvalid)
//                resp_ack_i            bready from the initiator
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_aw_w_join
    import cl_fsb_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic        req_v_o,
    output logic [31:0] req_addr_o,
    output logic [31:0] req_data_o,
    output logic [3:0]  req_strb_o,
    output logic        resp_pend_o,
    input  logic        resp_ack_i
);

    axil_wr_state_e state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [3:0]     strb_q, strb_d;
    logic           aw_fire;
    logic           w_fire;

    // Readies decode straight from the state register and are forced low
    // while reset is held so nothing is accepted during reset.
    assign awready_o   = aresetn && ((state_q == W_IDLE) || (state_q == W_HAVE_W));
    assign wready_o    = aresetn && ((state_q == W_IDLE) || (state_q == W_HAVE_AW));
    assign resp_pend_o = (state_q == W_RESP);

    assign aw_fire = awvalid_i && awready_o;
    assign w_fire  = wvalid_i  && wready_o;

    // The beat that completes the pair is still on the bus, so the request
    // mixes the stored half with the live half.
    assign req_addr_o = (state_q == W_HAVE_AW) ? addr_q : awaddr_i;
    assign req_data_o = (state_q == W_HAVE_W)  ? data_q : wdata_i;
    assign req_strb_o = (state_q == W_HAVE_W)  ? strb_q : wstrb_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        req_v_o = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    state_d = W_RESP;
                    req_v_o = 1'b1;
                end else if (aw_fire) begin
                    state_d = W_HAVE_AW;
                    addr_d  = awaddr_i;
                end else if (w_fire) begin
                    state_d = W_HAVE_W;
                    data_d  = wdata_i;
                    strb_d  = wstrb_i;
                end
            end
            W_HAVE_AW: begin
                if (w_fire) begin
                    state_d = W_RESP;
                    req_v_o = 1'b1;
                end
            end
            W_HAVE_W: begin
                if (aw_fire) begin
                    state_d = W_RESP;
                    req_v_o = 1'b1;
                end
            end
            W_RESP: begin
                if (resp_ack_i) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_regfile_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regfile_responder
//  Description : AXI-Lite register-file endpoint for one 4 KB crossbar port.
//                Word-decodes addr[11:2] into NUM_REGS 32-bit slots. Writable
//                slots are byte-strobed flops; read-only slots return
//                ro_data_i. Unmapped or read-only writes and unmapped reads
//                answer SLVERR.
//  Ports       : aclk, aresetn   clock, synchronous active-low reset
//                s_axil_bus      AXI-Lite responder side
//                reg_o           writable register image (RO slots are 0)
//                reg_wr_v_o      per-slot pulse the cycle after a write
//                ro_data_i       status values for RO slots, sampled at AR
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile_responder
    import cl_fsb_pkg::*;
#(
    parameter int                     NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0]    RO_MASK   = '0,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axil_bus_t.master                s_axil_bus,
    output logic [NUM_REGS*32-1:0]   reg_o,
    output logic [NUM_REGS-1:0]      reg_wr_v_o,
    input  logic [NUM_REGS*32-1:0]   ro_data_i
);

    localparam int IDX_W = AXIL_IDX_W;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                  wr_req_v;
    logic [31:0]           wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   reg_wr_v_q, reg_wr_v_d;
    logic [1:0]            bresp_q, bresp_d;

    axil_aw_w_join u_aw_w_join (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awaddr_i    (s_axil_bus.awaddr),
        .awvalid_i   (s_axil_bus.awvalid),
        .awready_o   (s_axil_bus.awready),
        .wdata_i     (s_axil_bus.wdata),
        .wstrb_i     (s_axil_bus.wstrb),
        .wvalid_i    (s_axil_bus.wvalid),
        .wready_o    (s_axil_bus.wready),
        .req_v_o     (wr_req_v),
        .req_addr_o  (wr_addr),
        .req_data_o  (wr_data),
        .req_strb_o  (wr_strb),
        .resp_pend_o (s_axil_bus.bvalid),
        .resp_ack_i  (s_axil_bus.bready)
    );

    assign wr_idx = wr_addr[AXIL_WIN_ADDR_BITS-1:2];

    // One slot per generate iteration. A slot can only match when its index
    // is below NUM_REGS, so the mapped check is implicit in the compare.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
        if (RO_MASK[gi]) begin : g_ro
            assign wr_hit[gi]          = 1'b0;
            assign reg_o[gi*32 +: 32]  = '0;
        end else begin : g_rw
            logic [31:0] slot_q, slot_d;

            assign wr_hit[gi] = wr_req_v && (wr_idx == IDX_W'(gi));

            always_comb begin
                slot_d = slot_q;
                if (wr_hit[gi]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            slot_d[b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    slot_q <= RESET_VAL[gi*32 +: 32];
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign reg_o[gi*32 +: 32] = slot_q;
        end
    end

    // A write is OKAY exactly when it hit a writable slot.
    always_comb begin
        reg_wr_v_d = wr_hit;
        bresp_d    = bresp_q;
        if (wr_req_v) begin
            bresp_d = (|wr_hit) ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            reg_wr_v_q <= '0;
            bresp_q    <= AXIL_RESP_OKAY;
        end else begin
            reg_wr_v_q <= reg_wr_v_d;
            bresp_q    <= bresp_d;
        end
    end

    assign reg_wr_v_o       = reg_wr_v_q;
    assign s_axil_bus.bresp = bresp_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    axil_rd_state_e        rd_state_q, rd_state_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [IDX_W-1:0]      rd_idx;
    logic [31:0]           rd_sel_data;
    logic [1:0]            rd_sel_resp;
    logic                  ar_fire;

    assign rd_idx             = s_axil_bus.araddr[AXIL_WIN_ADDR_BITS-1:2];
    assign s_axil_bus.arready = aresetn && (rd_state_q == R_IDLE);
    assign ar_fire            = s_axil_bus.arvalid && s_axil_bus.arready;

    // Reads sample the register flops before this cycle's write lands, so a
    // same-cycle read and write to one slot returns the old value.
    always_comb begin
        rd_sel_data = '0;
        rd_sel_resp = AXIL_RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel_resp = AXIL_RESP_OKAY;
                rd_sel_data = RO_MASK[i] ? ro_data_i[i*32 +: 32] : reg_o[i*32 +: 32];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_state_d = R_RESP;
                    rdata_d    = rd_sel_data;
                    rresp_d    = rd_sel_resp;
                end
            end
            R_RESP: begin
                if (s_axil_bus.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= AXIL_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axil_bus.rvalid = (rd_state_q == R_RESP);
    assign s_axil_bus.rdata  = rdata_q;
    assign s_axil_bus.rresp  = rresp_q;

    // Address bits outside the word index are ignored by design, and the
    // ro_data_i lanes of writable slots are never selected.
    logic unused_inputs;
    assign unused_inputs = ^{wr_addr[31:AXIL_WIN_ADDR_BITS], wr_addr[1:0],
                             s_axil_bus.araddr[31:AXIL_WIN_ADDR_BITS],
                             s_axil_bus.araddr[1:0], ro_data_i};

endmodule
`default_nettype wire

// File: tb/tb_axil_regfile_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_regfile_responder
//  Description : Self-checking bench for axil_regfile_responder. A
//                transaction-level model tracks captured beats, pending
//                responses and register contents; a per-cycle compare checks
//                the DUT against it. Directed cases pin literal values, then
//                randomized traffic runs with random back-pressure and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_regfile_responder;

    localparam int            N  = 16;
    localparam logic [N-1:0]  RO = 16'h0088;

    function automatic logic [N*32-1:0] mk_rv();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'h5A00_0000 | (32'(i) * 32'h0001_0101);
        v[31:0]  = 32'h0000_0000;
        v[63:32] = 32'hFFFF_FFFF;
        return v;
    endfunction

    localparam logic [N*32-1:0] RV = mk_rv();

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N*32-1:0] reg_o;
    logic [N-1:0]    reg_wr_v;
    logic [N*32-1:0] ro_data;

    always #5 clk = ~clk;

    axil_bus_t bus ();

    axil_regfile_responder #(
        .NUM_REGS  (N),
        .RO_MASK   (RO),
        .RESET_VAL (RV)
    ) dut (
        .aclk       (clk),
        .aresetn    (rstn),
        .s_axil_bus (bus),
        .reg_o      (reg_o),
        .reg_wr_v_o (reg_wr_v),
        .ro_data_i  (ro_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic chk_wide(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [N];
    logic [N-1:0] m_pulse;
    bit          m_aw_have, m_w_have, m_b_pend, m_r_pend, m_live;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;
    bit          m_aw_fired, m_w_fired, m_ar_fired;
    bit          aw_rdy, w_rdy, ar_rdy;
    int          m_idx;

    function automatic logic [N*32-1:0] m_flat();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[i*32 +: 32] = m_reg[i];
        return v;
    endfunction

    always @(posedge clk) begin
        m_aw_fired = 0;
        m_w_fired  = 0;
        m_ar_fired = 0;
        if (!rstn) begin
            m_live    = 1;
            m_aw_have = 0;
            m_w_have  = 0;
            m_b_pend  = 0;
            m_r_pend  = 0;
            m_pulse   = '0;
            for (int i = 0; i < N; i++) m_reg[i] = RO[i] ? 32'h0 : RV[i*32 +: 32];
        end else begin
            aw_rdy     = !m_aw_have && !m_b_pend;
            w_rdy      = !m_w_have && !m_b_pend;
            ar_rdy     = !m_r_pend;
            m_aw_fired = bus.awvalid && aw_rdy;
            m_w_fired  = bus.wvalid && w_rdy;
            m_ar_fired = bus.arvalid && ar_rdy;
            m_pulse    = '0;
            if (m_r_pend && bus.rready) m_r_pend = 0;
            if (m_ar_fired) begin
                m_idx    = int'(bus.araddr[11:2]);
                m_r_pend = 1;
                if (m_idx >= N) begin
                    m_rdata = 32'h0;
                    m_rresp = 2'b10;
                end else begin
                    m_rdata = RO[m_idx] ? ro_data[m_idx*32 +: 32] : m_reg[m_idx];
                    m_rresp = 2'b00;
                end
            end
            if (m_b_pend && bus.bready) m_b_pend = 0;
            if (m_aw_fired) begin
                m_aw_have = 1;
                m_aw_addr = bus.awaddr;
            end
            if (m_w_fired) begin
                m_w_have = 1;
                m_w_data = bus.wdata;
                m_w_strb = bus.wstrb;
            end
            if (m_aw_have && m_w_have) begin
                m_idx     = int'(m_aw_addr[11:2]);
                m_aw_have = 0;
                m_w_have  = 0;
                m_b_pend  = 1;
                if (m_idx < N && !RO[m_idx]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) m_reg[m_idx][b*8 +: 8] = m_w_data[b*8 +: 8];
                    m_pulse[m_idx] = 1'b1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("awready", 32'(bus.awready), 32'(rstn && !m_aw_have && !m_b_pend));
            chk("wready",  32'(bus.wready),  32'(rstn && !m_w_have && !m_b_pend));
            chk("arready", 32'(bus.arready), 32'(rstn && !m_r_pend));
            chk("bvalid",  32'(bus.bvalid),  32'(m_b_pend));
            if (m_b_pend) chk("bresp", 32'(bus.bresp), 32'(m_bresp));
            chk("rvalid",  32'(bus.rvalid),  32'(m_r_pend));
            if (m_r_pend) begin
                chk("rdata", bus.rdata, m_rdata);
                chk("rresp", 32'(bus.rresp), 32'(m_rresp));
            end
            chk_wide("reg_o", reg_o, m_flat());
            chk("reg_wr_v", 32'(reg_wr_v), 32'(m_pulse));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_aw_fired) bus.awvalid = 1'b0;
        if (m_w_fired)  bus.wvalid  = 1'b0;
        if (m_ar_fired) bus.arvalid = 1'b0;
    endtask

    task automatic run_until_idle(input string nm);
        int k;
        k = 0;
        while (k < 40 && (bus.awvalid || bus.wvalid || bus.arvalid)) begin
            tick();
            k++;
        end
        chk(nm, 32'(bus.awvalid || bus.wvalid || bus.arvalid), 32'h0);
    endtask

    task automatic set_aw(input logic [31:0] a);
        bus.awaddr = a; bus.awvalid = 1'b1;
    endtask
    task automatic set_w(input logic [31:0] d, input logic [3:0] s);
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    endtask
    task automatic set_ar(input logic [31:0] a);
        bus.araddr = a; bus.arvalid = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(16, 19)) << 2;
            default: a = 32'($urandom_range(0, 15)) << 2;
        endcase
        a[1:0] = 2'($urandom);
        if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
        return a;
    endfunction

    logic [N*32-1:0] snap;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        ro_data = '0;
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_awready", 32'(bus.awready), 32'h0);
        chk("rst_slot1", reg_o[63:32], 32'hFFFF_FFFF);
        chk("rst_slot3_ro", reg_o[127:96], 32'h0);
        rstn = 1'b1;
        tick();

        // Same-cycle AW+W to slot 2.
        set_aw(32'h008); set_w(32'hA5A5_A5A5, 4'hF);
        run_until_idle("to_wr_slot2");
        chk("wr2_bvalid", 32'(bus.bvalid), 32'h1);
        chk("wr2_bresp", 32'(bus.bresp), 32'h0);
        chk("wr2_slot2", reg_o[95:64], 32'hA5A5_A5A5);
        chk("wr2_pulse", 32'(reg_wr_v), 32'h0004);
        tick();
        chk("wr2_bvalid_done", 32'(bus.bvalid), 32'h0);
        chk("wr2_pulse_done", 32'(reg_wr_v), 32'h0);

        // W three cycles ahead of AW, partial strobe on slot 1.
        set_w(32'h1122_3344, 4'b0101);
        tick(); tick(); tick();
        set_aw(32'h004);
        run_until_idle("to_wr_slot1");
        chk("wr1_bvalid", 32'(bus.bvalid), 32'h1);
        chk("wr1_slot1", reg_o[63:32], 32'hFF22_FF44);
        tick();

        // Unmapped read and write.
        set_ar(32'h040);
        run_until_idle("to_rd_unmapped");
        chk("rd40_rresp", 32'(bus.rresp), 32'h2);
        chk("rd40_rdata", bus.rdata, 32'h0);
        tick();
        snap = reg_o;
        set_aw(32'h040); set_w(32'hDEAD_BEEF, 4'hF);
        run_until_idle("to_wr_unmapped");
        chk("wr40_bresp", 32'(bus.bresp), 32'h2);
        chk("wr40_pulse", 32'(reg_wr_v), 32'h0);
        chk_wide("wr40_regs", reg_o, snap);
        tick();

        // Read-only slot 3.
        ro_data[127:96] = 32'hCAFE_0003;
        set_ar(32'h00C);
        run_until_idle("to_rd_ro");
        chk("rdro_rdata", bus.rdata, 32'hCAFE_0003);
        chk("rdro_rresp", 32'(bus.rresp), 32'h0);
        tick();
        set_aw(32'h00C); set_w(32'h1234_5678, 4'hF);
        run_until_idle("to_wr_ro");
        chk("wrro_bresp", 32'(bus.bresp), 32'h2);
        chk("wrro_slot3", reg_o[127:96], 32'h0);
        tick();

        // Back-pressure: both responses held for 10 cycles.
        bus.bready = 1'b0; bus.rready = 1'b0;
        set_aw(32'h010); set_w(32'h0000_0044, 4'hF); set_ar(32'h004);
        run_until_idle("to_stall_issue");
        set_aw(32'h014); set_w(32'h0000_0055, 4'hF); set_ar(32'h008);
        repeat (10) tick();
        chk("stall_bvalid", 32'(bus.bvalid), 32'h1);
        chk("stall_rdata", bus.rdata, 32'hFF22_FF44);
        chk("stall_awready", 32'(bus.awready), 32'h0);
        chk("stall_arready", 32'(bus.arready), 32'h0);
        bus.bready = 1'b1; bus.rready = 1'b1;
        run_until_idle("to_stall_drain");
        tick(); tick();

        // Same-cycle read and write of slot 0.
        set_aw(32'h000); set_w(32'h0000_0005, 4'hF); set_ar(32'h000);
        run_until_idle("to_rw_same");
        chk("rw_old", bus.rdata, 32'h0);
        tick();
        set_ar(32'h000);
        run_until_idle("to_rw_reread");
        chk("rw_new", bus.rdata, 32'h5);
        tick();

        // Reset while holding only AW: the AW must be dropped.
        set_aw(32'h010);
        run_until_idle("to_rst_aw");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst_mid_slot2", reg_o[95:64], RV[95:64]);
        set_w(32'h0BAD_F00D, 4'hF);
        run_until_idle("to_rst_w");
        tick();
        chk("rst_mid_nob", 32'(bus.bvalid), 32'h0);
        set_aw(32'h010);
        run_until_idle("to_rst_aw2");
        chk("rst_after_b", 32'(bus.bvalid), 32'h1);
        chk("rst_after_slot4", reg_o[159:128], 32'h0BAD_F00D);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (!bus.awvalid && $urandom_range(0, 9) < 4) set_aw(rnd_addr());
            if (!bus.wvalid && $urandom_range(0, 9) < 4) set_w($urandom, 4'($urandom));
            if (!bus.arvalid && $urandom_range(0, 9) < 4) set_ar(rnd_addr());
            bus.bready = ($urandom_range(0, 9) < 7);
            bus.rready = ($urandom_range(0, 9) < 7);
            ro_data[127:96]  = $urandom;
            ro_data[255:224] = $urandom;
            rstn = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
